ntt_layer_scheduler: RTL

NTT_LAYER_SCHEDULER -- requirements
Module: ntt_layer_scheduler

---
 rtl/ntt_layer_scheduler_if.sv | 40 ++++
 rtl/ntt_layer_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_layer_scheduler_if.sv
// ---------------------------------------------------------------------------
// ntt_layer_scheduler_if
// Control and RAM/ROM addressing bundle of the NTT layer scheduler.
// Optional feature macro: NTT_SCHED_INVERSE_EN adds the 'inv' request bit.
// master: the requester side, which drives start/hold(/inv).
// slave : the scheduler itself.
// ---------------------------------------------------------------------------
interface ntt_layer_scheduler_if;
  logic       start;
  logic       hold;
`ifdef NTT_SCHED_INVERSE_EN
  logic       inv;
`endif
  logic [7:0] ram_addr_a;
  logic [7:0] ram_addr_b;
  logic       ram_we;
  logic [6:0] rom_addr;
  logic       busy;
  logic       done;

`ifdef NTT_SCHED_INVERSE_EN
  modport master (
    output start, hold, inv,
    input  ram_addr_a, ram_addr_b, ram_we, rom_addr, busy, done
  );
  modport slave (
    input  start, hold, inv,
    output ram_addr_a, ram_addr_b, ram_we, rom_addr, busy, done
  );
`else
  modport master (
    output start, hold,
    input  ram_addr_a, ram_addr_b, ram_we, rom_addr, busy, done
  );
  modport slave (
    input  start, hold,
    output ram_addr_a, ram_addr_b, ram_we, rom_addr, busy, done
  );
`endif
endinterface

// File: rtl/ntt_layer_scheduler.sv
// ---------------------------------------------------------------------------
// ntt_layer_scheduler
// Sequences the 7 layers x 128 butterflies of a 256-point NTT. Each
// butterfly is a READ cycle (addresses out, no write) followed by a WRITE
// cycle (same addresses, write strobe). Layer L uses stride len = 128>>L,
// group g = i>>(7-L), offset o = i&(len-1); a = g*2*len + o, b = a + len.
// Optional feature macro: NTT_SCHED_INVERSE_EN adds an 'inv' request bit
// that runs the layers from L=6 down to L=0 with mirrored twiddle indices.
// Reset is synchronous and active-low.
// ---------------------------------------------------------------------------
module ntt_layer_scheduler (
  input  logic                 clk,
  input  logic                 rst,
  ntt_layer_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic [2:0] l_r;
  logic [6:0] i_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [6:0] rom_r;
  logic       we_r;
  logic       busy_r;
  logic       done_r;

  logic       inv_s;
  logic       start_inv_s;
  logic [2:0] first_l_s;
  logic [2:0] next_l_s;
  logic [6:0] next_i_s;
  logic       last_bfly_s;
  logic [2:0] tgt_l_s;
  logic [6:0] tgt_i_s;
  logic       tgt_inv_s;
  logic [7:0] nxt_a_s;
  logic [7:0] nxt_b_s;
  logic [6:0] nxt_rom_s;

`ifdef NTT_SCHED_INVERSE_EN
  logic inv_r;
  assign inv_s       = inv_r;
  assign start_inv_s = bus.inv;
`else
  assign inv_s       = 1'b0;
  assign start_inv_s = 1'b0;
`endif

  // Inverse runs start at the finest layer (len 2), forward runs at len 128.
  assign first_l_s = start_inv_s ? 3'd6 : 3'd0;

  // Stride of layer lay.
  function automatic logic [7:0] len_f(input logic [2:0] lay);
    return 8'd128 >> lay;
  endfunction

  // Even-coefficient address g*2*len + o of butterfly idx in layer lay.
  function automatic logic [7:0] addr_a_f(input logic [2:0] lay, input logic [6:0] idx);
    logic [7:0] len_v;
    logic [7:0] grp_v;
    logic [7:0] off_v;
    len_v = len_f(lay);
    grp_v = {1'b0, idx} >> (3'd7 - lay);
    off_v = {1'b0, idx} & (len_v - 8'd1);
    return (grp_v << (4'd8 - {1'b0, lay})) + off_v;
  endfunction

  // Twiddle index: (1<<L)+g forward, ((2<<L)-1)-g inverse (modulo 128).
  function automatic logic [6:0] rom_f(input logic [2:0] lay, input logic [6:0] idx,
                                       input logic inv_v);
    logic [6:0] grp_v;
    logic [6:0] rom_v;
    grp_v = idx >> (3'd7 - lay);
    if (inv_v) begin
      rom_v = ((7'd2 << lay) - 7'd1) - grp_v;
    end else begin
      rom_v = (7'd1 << lay) + grp_v;
    end
    return rom_v;
  endfunction

  // Counter successor: i wraps 127->0 and steps the layer in run direction.
  always_comb begin
    next_i_s    = i_r + 7'd1;
    next_l_s    = l_r;
    last_bfly_s = 1'b0;
    if (i_r == 7'd127) begin
      if (inv_s) begin
        next_l_s    = l_r - 3'd1;
        last_bfly_s = (l_r == 3'd0);
      end else begin
        next_l_s    = l_r + 3'd1;
        last_bfly_s = (l_r == 3'd6);
      end
    end else begin
      next_l_s    = l_r;
      last_bfly_s = 1'b0;
    end
  end

  // Addresses of the butterfly entered at the next READ (first one from IDLE).
  always_comb begin
    tgt_l_s   = next_l_s;
    tgt_i_s   = next_i_s;
    tgt_inv_s = inv_s;
    if (state_r == IDLE) begin
      tgt_l_s   = first_l_s;
      tgt_i_s   = 7'd0;
      tgt_inv_s = start_inv_s;
    end else begin
      tgt_l_s   = next_l_s;
      tgt_i_s   = next_i_s;
      tgt_inv_s = inv_s;
    end
    nxt_a_s   = addr_a_f(tgt_l_s, tgt_i_s);
    nxt_b_s   = nxt_a_s + len_f(tgt_l_s);
    nxt_rom_s = rom_f(tgt_l_s, tgt_i_s, tgt_inv_s);
  end

  // Sequencing FSM with counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      l_r     <= 3'd0;
      i_r     <= 7'd0;
      a_r     <= 8'd0;
      b_r     <= 8'd0;
      rom_r   <= 7'd0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef NTT_SCHED_INVERSE_EN
      inv_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          we_r   <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= READ;
            l_r     <= first_l_s;
            i_r     <= 7'd0;
            a_r     <= nxt_a_s;
            b_r     <= nxt_b_s;
            rom_r   <= nxt_rom_s;
            busy_r  <= 1'b1;
`ifdef NTT_SCHED_INVERSE_EN
            inv_r   <= bus.inv;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        READ: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if (bus.hold) begin
            we_r <= 1'b0;
          end else begin
            state_r <= WRITE;
            we_r    <= 1'b1;
          end
        end
        WRITE: begin
          done_r <= 1'b0;
          if (bus.hold) begin
            // Frozen: the strobe stays armed and is masked at the port.
            we_r <= we_r;
          end else if (last_bfly_s) begin
            state_r <= DONE;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= READ;
            we_r    <= 1'b0;
            l_r     <= next_l_s;
            i_r     <= next_i_s;
            a_r     <= nxt_a_s;
            b_r     <= nxt_b_s;
            rom_r   <= nxt_rom_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_addr_a = a_r;
  assign bus.ram_addr_b = b_r;
  assign bus.rom_addr   = rom_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  // hold withdraws the strobe within the same cycle so a frozen WRITE never
  // writes; the armed strobe replays the WRITE once hold drops. we_r is zero
  // outside READ/WRITE, so hold has no effect there.
  assign bus.ram_we     = we_r & ~bus.hold;

endmodule
